// File: rtl/ysyx_24100005_regfile_sb.sv
// Register file with per-register scoreboard (busy) bits.
// N combinational read ports with write-through bypass, one write port,
// one reservation (mark) port and a global flush of the reservations.

// One read lane: selects stored data or the in-flight write and reports
// whether the selected register still waits for a writer.
module ysyx_24100005_regfile_sb_rdport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 32
) (
  input  logic [NREG-1:0][DATA_WIDTH-1:0] rf_i,
  input  logic [NREG-1:0]                 busy_i,
  input  logic [ADDR_WIDTH-1:0]           raddr_i,
  input  logic                            byp_en_i,
  input  logic [ADDR_WIDTH-1:0]           waddr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            busy_o
);
  logic hit;

  // byp_en_i already folds in wen, waddr!=0 and reset
  assign hit = byp_en_i && (waddr_i == raddr_i);

  // Data select: x0 is hardwired, then the forwarded write, then storage
  always_comb begin
    rdata_o = '0;
    if (raddr_i == '0)  rdata_o = '0;
    else if (hit)       rdata_o = wdata_i;
    else                rdata_o = rf_i[raddr_i];
  end

  // Forwarded data is already available, so it is not reported busy
  assign busy_o = busy_i[raddr_i] & ~hit;
endmodule

module ysyx_24100005_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [NR_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NR_RD*DATA_WIDTH-1:0]   rdata,
  input  logic                          mark_en,
  input  logic [ADDR_WIDTH-1:0]         mark_addr,
  input  logic                          flush,
  output logic [NR_RD-1:0]              busy,
  output logic                          idle
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
  logic [NREG-1:0]                 busy_q, busy_d;
  logic                            wr_vld, mk_vld, byp_en;

  assign wr_vld = wen && (waddr != '0);
  assign mk_vld = mark_en && (mark_addr != '0);
  // No forwarding while reset is held: outputs must read as cleared state
  assign byp_en = wr_vld && !rst;

  // Next register contents: single write port, x0 never stored
  always_comb begin
    rf_d = rf_q;
    if (wr_vld) rf_d[waddr] = wdata;
    rf_d[0] = '0;
  end

  // Next scoreboard: flush dominates; otherwise write clears, then mark
  // sets so a same-index mark+write leaves the new writer pending
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_vld) busy_d[waddr]     = 1'b0;
      if (mk_vld) busy_d[mark_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops every value and every reservation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q   <= '0;
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  // Idle reflects registered reservations only
  assign idle = ~|busy_q;

  for (genvar k = 0; k < NR_RD; k++) begin : g_rd
    ysyx_24100005_regfile_sb_rdport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NREG       (NREG)
    ) u_rd (
      .rf_i     (rf_q),
      .busy_i   (busy_q),
      .raddr_i  (raddr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .byp_en_i (byp_en),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .rdata_o  (rdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy_o   (busy[k])
    );
  end
endmodule

// File: tb/tb_ysyx_24100005_regfile_sb.sv
module tb_ysyx_24100005_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic          mark_en = 1'b0;
  logic [AW-1:0] mark_addr = '0;
  logic          flush = 1'b0;
  logic [NR-1:0] busy;
  logic          idle;

  int total = 0;
  int bad = 0;

  ysyx_24100005_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .mark_en(mark_en), .mark_addr(mark_addr),
    .flush(flush), .busy(busy), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          me;
    logic [AW-1:0] ma;
    logic          fl;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    eb;
    logic          ei;
  } tv_t;

  tv_t vec[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic me, input logic [AW-1:0] ma, input logic fl,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    wen = we; waddr = wa; wdata = wd; mark_en = me; mark_addr = ma; flush = fl;
    raddr = {r1, r0};
  endtask

  // reference model state
  logic [DW-1:0] mrf[NREG];
  bit            mbusy[NREG];

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    // directed cycle table: inputs applied for one cycle, outputs checked before the edge
    vec[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1};
    vec[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1};
    vec[2]  = '{1'b1, 5'd5, 32'h11,       1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h11, 32'h11, 2'b00, 1'b1};
    vec[3]  = '{1'b1, 5'd5, 32'h22,       1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h22, 32'h22, 2'b00, 1'b1};
    vec[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd5, 32'h0,  32'h22, 2'b00, 1'b1};
    vec[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 32'h0,  32'h22, 2'b01, 1'b0};
    vec[6]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 32'h77, 32'hDEADBEEF, 2'b00, 1'b0};
    vec[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 32'h77, 32'hDEADBEEF, 2'b00, 1'b1};
    vec[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 5'd9, 32'h0,  32'h0,  2'b00, 1'b1};
    vec[9]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 32'h99, 32'h0,  2'b00, 1'b0};
    vec[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 32'h99, 32'h0,  2'b01, 1'b0};
    vec[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd1, 5'd0, 32'h0,  32'h0,  2'b00, 1'b0};
    vec[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd1, 5'd2, 32'h0,  32'h0,  2'b01, 1'b0};
    vec[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 5'd2, 32'h0,  32'h0,  2'b10, 1'b0};
    vec[14] = '{1'b1, 5'd1, 32'hAB,       1'b1, 5'd3, 1'b1, 5'd1, 5'd0, 32'hAB, 32'h0,  2'b00, 1'b0};
    vec[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd1, 32'hDEADBEEF, 32'hAB, 2'b00, 1'b1};
    vec[16] = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 1'b1};
    vec[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 1'b1};

    // reset state, with write/mark/flush requests that must be ignored
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 1'b0, 5'd6, 5'd0);
    #1;
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_busy",  64'(busy),  64'h0);
    chk("rst_idle",  64'(idle),  64'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd0);
    #1;
    chk("rst_ignored_wr", 64'(rdata), 64'h0);
    chk("rst_ignored_mk", 64'(idle),  64'h1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vec[i].we, vec[i].wa, vec[i].wd, vec[i].me, vec[i].ma, vec[i].fl, vec[i].r0, vec[i].r1);
      #1;
      chk($sformatf("vec%0d_rdata0", i), 64'(rdata[DW-1:0]),    64'(vec[i].e0));
      chk($sformatf("vec%0d_rdata1", i), 64'(rdata[2*DW-1:DW]), 64'(vec[i].e1));
      chk($sformatf("vec%0d_busy", i),   64'(busy),             64'(vec[i].eb));
      chk($sformatf("vec%0d_idle", i),   64'(idle),             64'(vec[i].ei));
    end

    // asynchronous reset in the middle of a cycle with a pending reservation
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
    #1;
    chk("ar_pre_rdata", 64'(rdata[DW-1:0]), 64'h55);
    chk("ar_pre_busy",  64'(busy),          64'h3);
    chk("ar_pre_idle",  64'(idle),          64'h0);
    #1 rst = 1'b1;
    #1;
    chk("ar_rdata", 64'(rdata), 64'h0);
    chk("ar_busy",  64'(busy),  64'h0);
    chk("ar_idle",  64'(idle),  64'h1);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 1'b0, 5'd6, 5'd4);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd4);
    #1;
    chk("ar_post_rdata", 64'(rdata), 64'h0);
    chk("ar_post_idle",  64'(idle),  64'h1);

    // randomized run against a behavioural model (state is all-clear after reset)
    for (int r = 0; r < NREG; r++) begin
      mrf[r] = '0;
      mbusy[r] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] ra[NR];
      logic [DW-1:0] exp_d;
      logic          exp_b;
      logic          exp_idle;
      logic          do_rst;
      @(negedge clk);
      do_rst = ($urandom_range(0, 199) == 0);
      rst = do_rst;
      ra[0] = rnd_addr();
      ra[1] = ($urandom_range(0, 3) == 0) ? ra[0] : rnd_addr();
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 2) == 0), rnd_addr(), 1'($urandom_range(0, 29) == 0),
            ra[0], ra[1]);
      #1;
      if (do_rst) begin
        for (int r = 0; r < NREG; r++) begin
          mrf[r] = '0;
          mbusy[r] = 1'b0;
        end
      end
      exp_idle = 1'b1;
      for (int r = 0; r < NREG; r++) if (mbusy[r]) exp_idle = 1'b0;
      for (int k = 0; k < NR; k++) begin
        bit fwd;
        fwd = !do_rst && wen && waddr != 0 && waddr == ra[k];
        if (ra[k] == 0)  exp_d = '0;
        else if (fwd)    exp_d = wdata;
        else             exp_d = mrf[ra[k]];
        exp_b = mbusy[ra[k]] && !fwd;
        chk($sformatf("rnd%0d_rdata%0d", c, k), 64'(rdata[k*DW +: DW]), 64'(exp_d));
        chk($sformatf("rnd%0d_busy%0d", c, k),  64'(busy[k]),           64'(exp_b));
      end
      chk($sformatf("rnd%0d_idle", c), 64'(idle), 64'(exp_idle));
      // state change at the coming edge
      if (!do_rst) begin
        if (wen && waddr != 0) mrf[waddr] = wdata;
        if (flush) begin
          for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
        end else begin
          if (wen && waddr != 0) mbusy[waddr] = 1'b0;
          if (mark_en && mark_addr != 0) mbusy[mark_addr] = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_24100005_regfile_sb.md
YSYX_24100005_REGFILE_SB -- requirements
Module: ysyx_24100005_regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; the register count is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NR_RD, default 2, number of independent read ports.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wen  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_WIDTH  write index.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have port raddr  input  NR_RD*ADDR_WIDTH  packed read indices, port k at bits [ADDR_WIDTH*(k+1)-1 : ADDR_WIDTH*k].
REQ-010 SHALL have port rdata  output  NR_RD*DATA_WIDTH  packed read data, packed with the same ordering as raddr.
REQ-011 SHALL have port mark_en  input  1  reserve a destination: set its busy bit.
REQ-012 SHALL have port mark_addr  input  ADDR_WIDTH  index to reserve.
REQ-013 SHALL have port flush  input  1  clear all busy bits.
REQ-014 SHALL have port busy  output  NR_RD  busy[k] is the pending-write status of raddr port k.
REQ-015 SHALL have port idle  output  1  high when no busy bit is set.

Function
REQ-016 SHALL read register 0 as 0 on every port; writes to index 0 SHALL be ignored; busy bit 0 SHALL never be set.
REQ-017 SHALL write rf[waddr] <= wdata at posedge when wen=1 and waddr!=0.
REQ-018 SHALL drive rdata combinationally, with zero-cycle latency from raddr.
REQ-019 SHALL bypass writes: when wen=1, waddr!=0 and raddr[k]==waddr, rdata[k] SHALL equal wdata in the same cycle.
REQ-020 SHALL decode all NR_RD ports independently; identical indices on several ports SHALL return identical data.
REQ-021 SHALL keep a busy bit per register, updated at posedge as follows.
REQ-022 Busy priority: flush=1 SHALL clear all bits and ignore mark_en and wen in that cycle (the data write itself still happens).
REQ-023 Busy priority: without flush, mark_en=1 with mark_addr!=0 SHALL set busy[mark_addr].
REQ-024 Busy priority: without flush, wen=1 SHALL clear busy[waddr].
REQ-025 Busy priority: when mark and write target the same index in the same cycle, set SHALL win (a new writer is pending).
REQ-026 SHALL set busy[k] = busy_reg[raddr[k]] & ~(wen & waddr==raddr[k] & waddr!=0), so forwarded data is reported not busy.
REQ-027 SHALL set idle = ~|busy_reg, registered state only, not bypassed.
REQ-028 SHALL treat repeated mark of an already-busy index as idempotent (no counting).

Reset
REQ-029 SHALL, while rst=1, asynchronously clear all registers to 0 and all busy bits to 0; rdata SHALL be 0, busy SHALL be 0 and idle SHALL be 1.
REQ-030 SHALL ignore wen, mark_en and flush while rst=1; the first update SHALL occur on the first posedge after rst deasserts.
REQ-031 SHALL abort all pending reservations when rst asserts mid-operation; no reservation SHALL survive reset.

Verification
REQ-032 Bench SHALL cover write/read: wen=1, waddr=3, wdata=0xDEADBEEF; next cycle raddr0=3 -> rdata0=0xDEADBEEF; raddr1=0 -> rdata1=0.
REQ-033 Bench SHALL cover bypass: rf[5]=0x11; in the same cycle wen=1, waddr=5, wdata=0x22, raddr0=raddr1=5 -> rdata0=rdata1=0x22 and busy=0.
REQ-034 Bench SHALL cover scoreboard: mark 7 -> busy[raddr=7]=1 and idle=0; then write 7 -> next cycle busy=0 and idle=1.
REQ-035 Bench SHALL cover simultaneous mark and write: busy[9]=1; mark_en=1 with mark_addr=9 and wen=1 with waddr=9 -> after posedge busy[9]=1 and rf[9]=wdata.
REQ-036 Bench SHALL cover flush and zero: mark 1, 2 and 0 -> idle=0 with busy[0]=0; flush=1 -> next cycle idle=1; a write to 0 of 0xFFFF -> reading 0 returns 0.
REQ-037 Bench SHALL cover asynchronous reset: assert rst mid-cycle with busy[4]=1 and rf[4]=0x55 -> immediately rdata for index 4 = 0, busy=0 and idle=1, with no clock edge.
